if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS-style pipeline.
- Owns the PC and drives a req/ack instruction-memory port that may take several cycles.
- Delivers {pc+4, instruction, valid} directly into the decode stage's pc_in/inst inputs.
- Honours the hazard-unit freeze and the EXE-resolved branch redirect/flush.

---
 rtl/if_stage.sv | 128 ++++++++++++
 tb/tb_if_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with req/ack memory port and IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_address,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
);

    typedef enum logic {
        FETCH,
        HELD
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] pc_plus4;
    logic        redirect_pending, redirect_pending_nxt;
    logic [31:0] redirect_target, redirect_target_nxt;
    logic [31:0] held_inst, held_inst_nxt;
    logic        deliver;
    logic [31:0] deliver_pc, deliver_inst;
    logic [31:0] pc_out_nxt, inst_out_nxt;
    logic        inst_valid_nxt;

    assign pc_plus4  = pc + 32'd4;
    // Gated by rst so the port is quiet while reset is held, even though state is FETCH.
    assign imem_req  = (state == FETCH) && !rst;
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= FETCH;
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            redirect_target  <= 32'h0;
            held_inst        <= NOP_INST;
            pc_out           <= 32'h0;
            inst_out         <= NOP_INST;
            inst_valid       <= 1'b0;
        end else begin
            state            <= state_nxt;
            pc               <= pc_nxt;
            redirect_pending <= redirect_pending_nxt;
            redirect_target  <= redirect_target_nxt;
            held_inst        <= held_inst_nxt;
            pc_out           <= pc_out_nxt;
            inst_out         <= inst_out_nxt;
            inst_valid       <= inst_valid_nxt;
        end
    end

    always_comb begin
        state_nxt            = state;
        pc_nxt               = pc;
        redirect_pending_nxt = redirect_pending;
        redirect_target_nxt  = redirect_target;
        held_inst_nxt        = held_inst;
        deliver              = 1'b0;
        deliver_pc           = pc_plus4;
        deliver_inst         = imem_rdata;

        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (branch_taken || redirect_pending) begin
                        // Word belongs to the wrong path; drop it and jump.
                        pc_nxt               = branch_taken ? branch_address : redirect_target;
                        redirect_pending_nxt = 1'b0;
                    end else if (!freeze) begin
                        deliver = 1'b1;
                        pc_nxt  = pc_plus4;
                    end else begin
                        // pc already advances, so in HELD the buffered word's pc+4 is pc itself.
                        held_inst_nxt = imem_rdata;
                        pc_nxt        = pc_plus4;
                        state_nxt     = HELD;
                    end
                end else if (branch_taken) begin
                    redirect_pending_nxt = 1'b1;
                    redirect_target_nxt  = branch_address;
                end
            end
            HELD: begin
                if (branch_taken) begin
                    pc_nxt    = branch_address;
                    state_nxt = FETCH;
                end else if (!freeze) begin
                    deliver      = 1'b1;
                    deliver_pc   = pc;
                    deliver_inst = held_inst;
                    state_nxt    = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        pc_out_nxt     = 32'h0;
        inst_out_nxt   = NOP_INST;
        inst_valid_nxt = 1'b0;
        if (branch_taken) begin
            pc_out_nxt     = 32'h0;
            inst_out_nxt   = NOP_INST;
            inst_valid_nxt = 1'b0;
        end else if (freeze) begin
            pc_out_nxt     = pc_out;
            inst_out_nxt   = inst_out;
            inst_valid_nxt = inst_valid;
        end else if (deliver) begin
            pc_out_nxt     = deliver_pc;
            inst_out_nxt   = deliver_inst;
            inst_valid_nxt = 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
        .branch_address(branch_address), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_out(pc_out),
        .inst_out(inst_out), .inst_valid(inst_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic f,
                         input logic b, input logic [31:0] ba);
        imem_ack       = a;
        imem_rdata     = d;
        freeze         = f;
        branch_taken   = b;
        branch_address = ba;
    endtask

    task automatic test_reset;
        tick;
        checks++;
        if ({imem_req, pc_out, inst_out, inst_valid} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h",
                     {imem_req, pc_out, inst_out, inst_valid}, {1'b0, 32'h0, NOP, 1'b0});
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL reset_first_req: got %h expected %h", {imem_req, imem_addr}, {1'b1, RST_PC});
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        for (int i = 0; i < 3; i++) begin
            a = 32'(4 * i);
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, a}) begin
                errors++;
                $display("FAIL b2b_addr: got %h expected %h", {imem_req, imem_addr}, {1'b1, a});
            end
            drive(1'b1, mem_word(a), 1'b0, 1'b0, 32'h0);
            tick;
            checks++;
            if ({pc_out, inst_out, inst_valid} !== {a + 32'd4, mem_word(a), 1'b1}) begin
                errors++;
                $display("FAIL b2b_ifid: got %h expected %h",
                         {pc_out, inst_out, inst_valid}, {a + 32'd4, mem_word(a), 1'b1});
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_wait_states;
        logic [31:0] p;
        p = 32'hC;
        repeat (3) begin
            checks++;
            if ({imem_req, imem_addr} !== {1'b1, p}) begin
                errors++;
                $display("FAIL wait_addr: got %h expected %h", {imem_req, imem_addr}, {1'b1, p});
            end
            drive(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
            tick;
            checks++;
            if ({pc_out, inst_out, inst_valid} !== {32'h0, NOP, 1'b0}) begin
                errors++;
                $display("FAIL wait_bubble: got %h expected %h",
                         {pc_out, inst_out, inst_valid}, {32'h0, NOP, 1'b0});
            end
        end
        drive(1'b1, mem_word(p), 1'b0, 1'b0, 32'h0);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc_out, inst_out, inst_valid} !== {32'h10, mem_word(p), 1'b1}) begin
            errors++;
            $display("FAIL wait_ifid: got %h expected %h",
                     {pc_out, inst_out, inst_valid}, {32'h10, mem_word(p), 1'b1});
        end
    endtask

    task automatic test_freeze;
        drive(1'b1, mem_word(32'h10), 1'b1, 1'b0, 32'h0);
        tick;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({imem_req, pc_out, inst_out, inst_valid} !== {1'b0, 32'h10, mem_word(32'hC), 1'b1}) begin
                errors++;
                $display("FAIL freeze_hold: got %h expected %h",
                         {imem_req, pc_out, inst_out, inst_valid}, {1'b0, 32'h10, mem_word(32'hC), 1'b1});
            end
            if (i < 3) begin
                drive(1'b1, 32'hBAD0_0000, 1'b1, 1'b0, 32'h0);
                tick;
            end
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick;
        checks++;
        if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !==
            {1'b1, 32'h14, 32'h14, mem_word(32'h10), 1'b1}) begin
            errors++;
            $display("FAIL freeze_release: got %h expected %h",
                     {imem_req, imem_addr, pc_out, inst_out, inst_valid},
                     {1'b1, 32'h14, 32'h14, mem_word(32'h10), 1'b1});
        end
    endtask

    task automatic test_branch_pending;
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        tick;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({imem_req, imem_addr, inst_out, inst_valid} !== {1'b1, 32'h14, NOP, 1'b0}) begin
                errors++;
                $display("FAIL branch_pending_hold: got %h expected %h",
                         {imem_req, imem_addr, inst_out, inst_valid}, {1'b1, 32'h14, NOP, 1'b0});
            end
            drive(i == 1, mem_word(32'h14), 1'b0, 1'b0, $urandom & 32'hFFFF_FFFC);
            tick;
        end
        checks++;
        if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !== {1'b1, 32'h100, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL branch_discard: got %h expected %h",
                     {imem_req, imem_addr, pc_out, inst_out, inst_valid}, {1'b1, 32'h100, 32'h0, NOP, 1'b0});
        end
        drive(1'b1, mem_word(32'h100), 1'b0, 1'b0, 32'h0);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({pc_out, inst_out, inst_valid} !== {32'h104, mem_word(32'h100), 1'b1}) begin
            errors++;
            $display("FAIL branch_target_fetch: got %h expected %h",
                     {pc_out, inst_out, inst_valid}, {32'h104, mem_word(32'h100), 1'b1});
        end
    endtask

    task automatic test_branch_freeze;
        drive(1'b1, mem_word(32'h104), 1'b1, 1'b1, 32'h200);
        tick;
        checks++;
        if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !== {1'b1, 32'h200, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL branch_freeze_flush: got %h expected %h",
                     {imem_req, imem_addr, pc_out, inst_out, inst_valid}, {1'b1, 32'h200, 32'h0, NOP, 1'b0});
        end
        drive(1'b1, mem_word(32'h200), 1'b1, 1'b0, 32'h0);
        tick;
        checks++;
        if ({imem_req, pc_out, inst_out, inst_valid} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL held_entry: got %h expected %h",
                     {imem_req, pc_out, inst_out, inst_valid}, {1'b0, 32'h0, NOP, 1'b0});
        end
        drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick;
        checks++;
        if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !== {1'b1, 32'hFFFF_FFFC, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL held_branch: got %h expected %h",
                     {imem_req, imem_addr, pc_out, inst_out, inst_valid}, {1'b1, 32'hFFFF_FFFC, 32'h0, NOP, 1'b0});
        end
        drive(1'b1, mem_word(32'hFFFF_FFFC), 1'b0, 1'b0, 32'h0);
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checks++;
        if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !==
            {1'b1, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1}) begin
            errors++;
            $display("FAIL pc_wrap: got %h expected %h",
                     {imem_req, imem_addr, pc_out, inst_out, inst_valid},
                     {1'b1, 32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1});
        end
    endtask

    task automatic test_reset_mid_fetch;
        drive(1'b1, 32'hBAD1_1111, 1'b0, 1'b1, 32'h3C);
        tick;
        drive(1'b1, mem_word(32'h3C), 1'b0, 1'b0, 32'h0);
        tick;
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick;
        checks++;
        if ({imem_req, imem_addr, pc_out, inst_out, inst_valid} !==
            {1'b1, 32'h40, 32'h40, mem_word(32'h3C), 1'b1}) begin
            errors++;
            $display("FAIL pre_reset_state: got %h expected %h",
                     {imem_req, imem_addr, pc_out, inst_out, inst_valid},
                     {1'b1, 32'h40, 32'h40, mem_word(32'h3C), 1'b1});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, pc_out, inst_out, inst_valid} !== {1'b0, 32'h0, NOP, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h",
                     {imem_req, pc_out, inst_out, inst_valid}, {1'b0, 32'h0, NOP, 1'b0});
        end
        tick;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin
            errors++;
            $display("FAIL reset_restart: got %h expected %h", {imem_req, imem_addr}, {1'b1, RST_PC});
        end
    endtask

    // Reference: fetch pc, a pending redirect, and a one-deep hold slot for a word stalled by freeze.
    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] inst;
    } word_t;

    task automatic test_random;
        logic [31:0] m_pc;
        logic        m_redir;
        logic [31:0] m_target;
        word_t       hold_q[$];
        logic [64:0] m_ifid;
        logic        exp_req;
        logic        have_new;
        word_t       w;

        tick;
        m_pc     = RST_PC;
        m_redir  = 1'b0;
        m_target = 32'h0;
        m_ifid   = {32'h0, NOP, 1'b0};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            exp_req = (hold_q.size() == 0);
            checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc)) begin
                errors++;
                $display("FAIL rnd_fetch cyc %0d: got req=%b addr=%h expected req=%b addr=%h",
                         cyc, imem_req, imem_addr, exp_req, m_pc);
            end
            checks++;
            if ({pc_out, inst_out, inst_valid} !== m_ifid) begin
                errors++;
                $display("FAIL rnd_ifid cyc %0d: got %h expected %h", cyc, {pc_out, inst_out, inst_valid}, m_ifid);
            end
            if (inst_valid === 1'b1) begin
                checks++;
                if (inst_out !== mem_word(pc_out - 32'd4)) begin
                    errors++;
                    $display("FAIL rnd_memory cyc %0d: got %h expected %h", cyc, inst_out, mem_word(pc_out - 32'd4));
                end
            end

            drive(exp_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0),
                  exp_req ? mem_word(m_pc) : $urandom,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 9) == 0,
                  ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC));

            have_new = 1'b0;
            w = '0;
            if (exp_req) begin
                if (imem_ack) begin
                    if (branch_taken || m_redir) begin
                        m_pc    = branch_taken ? branch_address : m_target;
                        m_redir = 1'b0;
                    end else begin
                        w.pc4  = m_pc + 32'd4;
                        w.inst = imem_rdata;
                        m_pc   = m_pc + 32'd4;
                        if (freeze) hold_q.push_back(w);
                        else have_new = 1'b1;
                    end
                end else if (branch_taken) begin
                    m_redir  = 1'b1;
                    m_target = branch_address;
                end
            end else if (branch_taken) begin
                hold_q.delete();
                m_pc = branch_address;
            end else if (!freeze) begin
                w = hold_q.pop_front();
                have_new = 1'b1;
            end

            if (branch_taken)  m_ifid = {32'h0, NOP, 1'b0};
            else if (freeze)   m_ifid = m_ifid;
            else if (have_new) m_ifid = {w.pc4, w.inst, 1'b1};
            else               m_ifid = {32'h0, NOP, 1'b0};

            tick;
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_wait_states;
        test_freeze;
        test_branch_pending;
        test_branch_freeze;
        test_reset_mid_fetch;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
